// File: rtl/nios_system_entity_pos_out.sv
// Avalon-MM entity position port: software loads shadow X/Y/visibility and requests
// a commit; the shadows reach the renderer outputs only on a frame_start pulse.
module nios_system_entity_pos_out #(
  parameter int                    DATA_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_X    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_Y    = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic                  frame_start,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic                  out_visible
);

  logic [DATA_WIDTH-1:0] shadow_x_q, shadow_x_d;
  logic [DATA_WIDTH-1:0] shadow_y_q, shadow_y_d;
  logic                  shadow_vis_q, shadow_vis_d;
  logic                  pending_q, pending_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic [DATA_WIDTH-1:0] out_x_q, out_x_d;
  logic [DATA_WIDTH-1:0] out_y_q, out_y_d;
  logic                  out_visible_q, out_visible_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  wr;
  logic                  unused_wd;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = &{1'b0, writedata};

  always_comb begin
    shadow_x_d    = shadow_x_q;
    shadow_y_d    = shadow_y_q;
    shadow_vis_d  = shadow_vis_q;
    pending_d     = pending_q;
    frame_count_d = frame_count_q;
    out_x_d       = out_x_q;
    out_y_d       = out_y_q;
    out_visible_d = out_visible_q;

    // Transfer uses the registered shadows, so a same-cycle shadow write lands next frame.
    if (frame_start) begin
      frame_count_d = frame_count_q + 16'd1;
      if (pending_q) begin
        out_x_d       = shadow_x_q;
        out_y_d       = shadow_y_q;
        out_visible_d = shadow_vis_q;
        pending_d     = 1'b0;
      end
    end

    // Writes come after the frame logic so a new commit or a count clear wins.
    if (wr) begin
      unique case (address)
        2'd0: shadow_x_d = writedata[DATA_WIDTH-1:0];
        2'd1: shadow_y_d = writedata[DATA_WIDTH-1:0];
        2'd2: begin
          shadow_vis_d = writedata[0];
          if (writedata[1]) pending_d = 1'b1;
        end
        default: frame_count_d = 16'd0;
      endcase
    end
  end

  always_comb begin
    readdata_d = 32'd0;
    unique case (address)
      2'd0:    readdata_d = {{(32-DATA_WIDTH){1'b0}}, shadow_x_q};
      2'd1:    readdata_d = {{(32-DATA_WIDTH){1'b0}}, shadow_y_q};
      2'd2:    readdata_d = {30'd0, pending_q, shadow_vis_q};
      default: readdata_d = {16'd0, frame_count_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_x_q    <= RESET_X;
      shadow_y_q    <= RESET_Y;
      shadow_vis_q  <= 1'b0;
      pending_q     <= 1'b0;
      frame_count_q <= 16'd0;
      out_x_q       <= RESET_X;
      out_y_q       <= RESET_Y;
      out_visible_q <= 1'b0;
      readdata_q    <= 32'd0;
    end else begin
      shadow_x_q    <= shadow_x_d;
      shadow_y_q    <= shadow_y_d;
      shadow_vis_q  <= shadow_vis_d;
      pending_q     <= pending_d;
      frame_count_q <= frame_count_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      out_visible_q <= out_visible_d;
      readdata_q    <= readdata_d;
    end
  end

  assign readdata    = readdata_q;
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign out_visible = out_visible_q;

endmodule

// File: tb/tb_nios_system_entity_pos_out.sv
// Directed bench for nios_system_entity_pos_out: register access, frame-synchronous
// commit, same-cycle collisions, frame counter wrap and mid-operation reset.
module tb_nios_system_entity_pos_out;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic          frame_start = 1'b0;
  logic [DW-1:0] out_x;
  logic [DW-1:0] out_y;
  logic          out_visible;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] rv;

  nios_system_entity_pos_out #(.DATA_WIDTH(DW), .RESET_X('0), .RESET_Y('0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .frame_start(frame_start), .out_x(out_x), .out_y(out_y), .out_visible(out_visible)
  );

  always #5 clk = ~clk;

  // One clock with an optional write and an optional frame_start in the same cycle.
  task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d, input logic fs);
    chipselect  = w;
    write_n     = ~w;
    address     = a;
    writedata   = d;
    frame_start = fs;
    @(posedge clk); #1;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    frame_start = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    @(posedge clk); #1;
    v = readdata;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL rst_readdata got %h want 0", readdata); end
    n_chk++; if (out_x !== 10'd0) begin n_fail++; $display("FAIL rst_out_x got %h want 0", out_x); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), rv);
      n_chk++; if (rv !== 32'd0) begin n_fail++; $display("FAIL rst_read%0d got %h want 0", i, rv); end
    end
    n_chk++; if (out_x !== 10'd0 || out_y !== 10'd0 || out_visible !== 1'b0) begin
      n_fail++; $display("FAIL rst_outs got %h/%h/%b want 0/0/0", out_x, out_y, out_visible); end
  endtask

  task automatic test_basic_commit();
    cyc(1, 2'd0, 32'h140, 0);
    cyc(1, 2'd1, 32'h0F0, 0);
    cyc(1, 2'd2, 32'h3, 0);
    n_chk++; if (out_x !== 10'd0) begin n_fail++; $display("FAIL pre_commit_x got %h want 0", out_x); end
    rd(2'd2, rv);
    n_chk++; if (rv !== 32'h3) begin n_fail++; $display("FAIL pending_set got %h want 3", rv); end
    cyc(0, 2'd0, 0, 1);
    n_chk++; if (out_x !== 10'h140 || out_y !== 10'h0F0 || out_visible !== 1'b1) begin
      n_fail++; $display("FAIL commit_outs got %h/%h/%b want 140/0f0/1", out_x, out_y, out_visible); end
    rd(2'd2, rv);
    n_chk++; if (rv !== 32'h1) begin n_fail++; $display("FAIL pending_clr got %h want 1", rv); end
    rd(2'd1, rv);
    n_chk++; if (rv !== 32'h0F0) begin n_fail++; $display("FAIL read_y got %h want 0f0", rv); end
  endtask

  task automatic test_no_commit();
    cyc(1, 2'd3, 0, 0);
    cyc(1, 2'd0, 32'h2A0, 0);
    cyc(0, 2'd0, 0, 1);
    cyc(0, 2'd0, 0, 1);
    n_chk++; if (out_x !== 10'h140) begin n_fail++; $display("FAIL nocommit_x got %h want 140", out_x); end
    rd(2'd3, rv);
    n_chk++; if (rv !== 32'h2) begin n_fail++; $display("FAIL frame_cnt got %h want 2", rv); end
    rd(2'd0, rv);
    n_chk++; if (rv !== 32'h2A0) begin n_fail++; $display("FAIL shadow_x got %h want 2a0", rv); end
  endtask

  task automatic test_collision();
    cyc(1, 2'd0, 32'h010, 0);
    cyc(1, 2'd2, 32'h3, 0);
    // Shadow write during transfer: old shadow goes out, pending clears.
    cyc(1, 2'd0, 32'h020, 1);
    n_chk++; if (out_x !== 10'h010) begin n_fail++; $display("FAIL coll_x got %h want 010", out_x); end
    rd(2'd2, rv);
    n_chk++; if (rv !== 32'h1) begin n_fail++; $display("FAIL coll_pend got %h want 1", rv); end
    // Commit with frame_start while idle: no transfer, pending set.
    cyc(1, 2'd2, 32'h3, 1);
    n_chk++; if (out_x !== 10'h010) begin n_fail++; $display("FAIL idle_commit_x got %h want 010", out_x); end
    rd(2'd2, rv);
    n_chk++; if (rv !== 32'h3) begin n_fail++; $display("FAIL idle_commit_pend got %h want 3", rv); end
    cyc(0, 2'd0, 0, 1);
    n_chk++; if (out_x !== 10'h020) begin n_fail++; $display("FAIL next_frame_x got %h want 020", out_x); end
    // Commit with frame_start while pending: pre-write shadows go out, pending stays.
    cyc(1, 2'd0, 32'h030, 0);
    cyc(1, 2'd2, 32'h3, 0);
    cyc(1, 2'd2, 32'h2, 1);
    n_chk++; if (out_x !== 10'h030 || out_visible !== 1'b1) begin
      n_fail++; $display("FAIL pend_commit got %h/%b want 030/1", out_x, out_visible); end
    rd(2'd2, rv);
    n_chk++; if (rv !== 32'h2) begin n_fail++; $display("FAIL pend_commit_reg got %h want 2", rv); end
    cyc(0, 2'd0, 0, 1);
    n_chk++; if (out_visible !== 1'b0) begin n_fail++; $display("FAIL pend_commit_vis got %b want 0", out_visible); end
  endtask

  task automatic test_counter();
    cyc(1, 2'd3, 0, 0);
    frame_start = 1'b1;
    repeat (65535) @(posedge clk);
    #1 frame_start = 1'b0;
    rd(2'd3, rv);
    n_chk++; if (rv !== 32'hFFFF) begin n_fail++; $display("FAIL cnt_max got %h want ffff", rv); end
    cyc(0, 2'd0, 0, 1);
    rd(2'd3, rv);
    n_chk++; if (rv !== 32'h0) begin n_fail++; $display("FAIL cnt_wrap got %h want 0", rv); end
    cyc(0, 2'd0, 0, 1);
    cyc(0, 2'd0, 0, 1);
    cyc(1, 2'd3, 0, 1);
    rd(2'd3, rv);
    n_chk++; if (rv !== 32'h0) begin n_fail++; $display("FAIL cnt_clear_win got %h want 0", rv); end
  endtask

  task automatic test_mid_reset();
    cyc(1, 2'd0, 32'h155, 0);
    cyc(1, 2'd2, 32'h3, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_chk++; if (out_x !== 10'd0 || out_visible !== 1'b0 || readdata !== 32'd0) begin
      n_fail++; $display("FAIL async_rst got %h/%b/%h want 0/0/0", out_x, out_visible, readdata); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(0, 2'd0, 0, 1);
    n_chk++; if (out_x !== 10'd0 || out_y !== 10'd0 || out_visible !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_outs got %h/%h/%b want 0/0/0", out_x, out_y, out_visible); end
    for (int i = 0; i < 3; i++) begin
      rd(2'(i), rv);
      n_chk++; if (rv !== 32'd0) begin n_fail++; $display("FAIL post_rst_read%0d got %h want 0", i, rv); end
    end
    rd(2'd3, rv);
    n_chk++; if (rv !== 32'h1) begin n_fail++; $display("FAIL post_rst_cnt got %h want 1", rv); end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_no_commit();
    test_collision();
    test_counter();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
